// File: rtl/regfile_pkg.sv
// Shared widths and requester indices for the register-file writeback arbiter.
package regfile_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_idx_e;

    function automatic req_idx_e other_req(input req_idx_e r);
        return (r == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Valid/ready writeback request bundle: one register address plus write data.
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic                  valid;
    logic                  ready;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/wb_slot.sv
// Single-entry writeback holding slot; accepts a new entry when empty or when
// its current entry is being popped, so a granted slot can refill on the same edge.
module wb_slot
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_arbiter_if.slave   req,
    input  logic                  pop,
    output logic                  full,
    output logic [REG_ADDR_W-1:0] addr,
    output logic [DATA_W-1:0]     data
);

    logic                  full_q, full_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  push;

    // Ready depends only on slot state and the grant, never on the incoming valid.
    assign req.ready = rst_n & (~full_q | pop);
    assign push      = req.valid & req.ready;

    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        if (push) begin
            full_d = 1'b1;
            addr_d = req.addr;
            data_d = req.data;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign addr = addr_q;
    assign data = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter with busy scoreboard.
// WB_ROUND_ROBIN_EN selects round-robin ties; otherwise the load unit (B) wins ties.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0]     a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0]     b_data,
    input  logic                  rsv_valid,
    input  logic [REG_ADDR_W-1:0] rsv_addr,
    output logic                  write_enable,
    output logic [REG_ADDR_W-1:0] WA,
    output logic [DATA_W-1:0]     WD,
    output logic [NUM_REGS-1:0]   busy,
    output logic [15:0]           conflict_cnt
);

    regfile_wb_arbiter_if a_if ();
    regfile_wb_arbiter_if b_if ();

    assign a_if.valid = a_valid;
    assign a_if.addr  = a_addr;
    assign a_if.data  = a_data;
    assign a_ready    = a_if.ready;
    assign b_if.valid = b_valid;
    assign b_if.addr  = b_addr;
    assign b_if.data  = b_data;
    assign b_ready    = b_if.ready;

    logic                  full_a, full_b;
    logic [REG_ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0]     data_a, data_b;
    logic                  pop_a, pop_b;

    wb_slot u_slot_a (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .req   (a_if),
        .pop   (pop_a),
        .full  (full_a),
        .addr  (addr_a),
        .data  (data_a)
    );

    wb_slot u_slot_b (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .req   (b_if),
        .pop   (pop_b),
        .full  (full_b),
        .addr  (addr_b),
        .data  (data_b)
    );

    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0]     wd_q, wd_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic [15:0]           conflict_cnt_q, conflict_cnt_d;
`ifdef WB_ROUND_ROBIN_EN
    req_idx_e              prio_q, prio_d;
`endif

    logic                  grant_valid;
    req_idx_e              grant_idx;
    logic [REG_ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0]     gnt_data;

    always_comb begin
        grant_valid = full_a | full_b;
        grant_idx   = REQ_A;
        if (full_a && full_b) begin
`ifdef WB_ROUND_ROBIN_EN
            grant_idx = prio_q;
`else
            grant_idx = REQ_B;
`endif
        end else if (full_b) begin
            grant_idx = REQ_B;
        end
    end

    assign pop_a    = full_a & (grant_idx == REQ_A);
    assign pop_b    = full_b & (grant_idx == REQ_B);
    assign gnt_addr = (grant_idx == REQ_B) ? addr_b : addr_a;
    assign gnt_data = (grant_idx == REQ_B) ? data_b : data_a;

    // Register 0 entries are drained without a write; set wins over clear in busy.
    always_comb begin
        we_d = 1'b0;
        wa_d = wa_q;
        wd_d = wd_q;
        if (grant_valid && (gnt_addr != '0)) begin
            we_d = 1'b1;
            wa_d = gnt_addr;
            wd_d = gnt_data;
        end

        busy_d = busy_q;
        if (we_q) begin
            busy_d[wa_q] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;

        conflict_cnt_d = conflict_cnt_q;
        if (full_a && full_b && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

`ifdef WB_ROUND_ROBIN_EN
    always_comb begin
        prio_d = prio_q;
        if (grant_valid) begin
            prio_d = other_req(grant_idx);
        end
    end
`endif

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            we_q           <= 1'b0;
            wa_q           <= '0;
            wd_q           <= '0;
            busy_q         <= '0;
            conflict_cnt_q <= '0;
`ifdef WB_ROUND_ROBIN_EN
            prio_q         <= REQ_A;
`endif
        end else begin
            we_q           <= we_d;
            wa_q           <= wa_d;
            wd_q           <= wd_d;
            busy_q         <= busy_d;
            conflict_cnt_q <= conflict_cnt_d;
`ifdef WB_ROUND_ROBIN_EN
            prio_q         <= prio_d;
`endif
        end
    end

    assign write_enable = we_q;
    assign WA           = wa_q;
    assign WD           = wd_q;
    assign busy         = busy_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; inputs change and outputs
// are sampled on the falling clock edge.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic                  CLOCK_50;
    logic                  reset_n;
    logic                  rsv_valid;
    logic [REG_ADDR_W-1:0] rsv_addr;
    logic                  write_enable;
    logic [REG_ADDR_W-1:0] WA;
    logic [DATA_W-1:0]     WD;
    logic [NUM_REGS-1:0]   busy;
    logic [15:0]           conflict_cnt;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_cnt;

    regfile_wb_arbiter_if a_bus ();
    regfile_wb_arbiter_if b_bus ();

    regfile_wb_arbiter dut (
        .CLOCK_50     (CLOCK_50),
        .reset_n      (reset_n),
        .a_valid      (a_bus.valid),
        .a_ready      (a_bus.ready),
        .a_addr       (a_bus.addr),
        .a_data       (a_bus.data),
        .b_valid      (b_bus.valid),
        .b_ready      (b_bus.ready),
        .b_addr       (b_bus.addr),
        .b_data       (b_bus.data),
        .rsv_valid    (rsv_valid),
        .rsv_addr     (rsv_addr),
        .write_enable (write_enable),
        .WA           (WA),
        .WD           (WD),
        .busy         (busy),
        .conflict_cnt (conflict_cnt)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic test_reset;
        reset_n = 1'b0;
        @(negedge CLOCK_50);
        checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL rst_we: got %0h expected 0", write_enable); end
        checks++; if (WA !== 3'd0) begin errors++; $display("[TB] FAIL rst_wa: got %0h expected 0", WA); end
        checks++; if (WD !== 32'd0) begin errors++; $display("[TB] FAIL rst_wd: got %0h expected 0", WD); end
        checks++; if (busy !== 8'h00) begin errors++; $display("[TB] FAIL rst_busy: got %0h expected 0", busy); end
        checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rst_cnt: got %0h expected 0", conflict_cnt); end
        checks++; if (a_bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_a_ready: got %0h expected 0", a_bus.ready); end
        checks++; if (b_bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_b_ready: got %0h expected 0", b_bus.ready); end
        reset_n = 1'b1;
        @(negedge CLOCK_50);
        checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL rel_we: got %0h expected 0", write_enable); end
        checks++; if (a_bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL rel_a_ready: got %0h expected 1", a_bus.ready); end
        checks++; if (b_bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL rel_b_ready: got %0h expected 1", b_bus.ready); end
        exp_cnt = 16'd0;
    endtask

`ifdef WB_ROUND_ROBIN_EN
    task automatic test_round_robin;
        logic exp_a;
        logic [REG_ADDR_W-1:0] exp_wa;
        logic [DATA_W-1:0] exp_wd;
        a_bus.valid = 1'b1; a_bus.addr = 3'd1; a_bus.data = 32'hAAAA_0001;
        b_bus.valid = 1'b1; b_bus.addr = 3'd2; b_bus.data = 32'hBBBB_0002;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLOCK_50);
            exp_a = (k % 2 == 1);
            checks++; if (a_bus.ready !== exp_a) begin errors++; $display("[TB] FAIL rr_a_ready[%0d]: got %0h expected %0h", k, a_bus.ready, exp_a); end
            checks++; if (b_bus.ready !== !exp_a) begin errors++; $display("[TB] FAIL rr_b_ready[%0d]: got %0h expected %0h", k, b_bus.ready, !exp_a); end
            if (k >= 2) begin
                exp_wa = (k % 2 == 0) ? 3'd1 : 3'd2;
                exp_wd = (k % 2 == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002;
                checks++; if (write_enable !== 1'b1) begin errors++; $display("[TB] FAIL rr_we[%0d]: got %0h expected 1", k, write_enable); end
                checks++; if (WA !== exp_wa) begin errors++; $display("[TB] FAIL rr_wa[%0d]: got %0h expected %0h", k, WA, exp_wa); end
                checks++; if (WD !== exp_wd) begin errors++; $display("[TB] FAIL rr_wd[%0d]: got %0h expected %0h", k, WD, exp_wd); end
            end
        end
        a_bus.valid = 1'b0; b_bus.valid = 1'b0;
        @(negedge CLOCK_50);
        checks++; if (WA !== 3'd2) begin errors++; $display("[TB] FAIL rr_drain_wa0: got %0h expected 2", WA); end
        checks++; if (conflict_cnt !== 16'd8) begin errors++; $display("[TB] FAIL rr_cnt: got %0h expected 8", conflict_cnt); end
        @(negedge CLOCK_50);
        checks++; if (WA !== 3'd1) begin errors++; $display("[TB] FAIL rr_drain_wa1: got %0h expected 1", WA); end
        @(negedge CLOCK_50);
        checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle_we: got %0h expected 0", write_enable); end
        checks++; if (conflict_cnt !== 16'd8) begin errors++; $display("[TB] FAIL rr_cnt_hold: got %0h expected 8", conflict_cnt); end
        exp_cnt = 16'd8;
    endtask
`else
    task automatic test_fixed_priority;
        a_bus.valid = 1'b1; a_bus.addr = 3'd1; a_bus.data = 32'h0000_0011;
        b_bus.valid = 1'b1; b_bus.addr = 3'd2; b_bus.data = 32'h0000_0022;
        @(negedge CLOCK_50);
        a_bus.valid = 1'b0; b_bus.valid = 1'b0;
        checks++; if (a_bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL fp_a_ready: got %0h expected 0", a_bus.ready); end
        checks++; if (b_bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL fp_b_ready: got %0h expected 1", b_bus.ready); end
        checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL fp_we0: got %0h expected 0", write_enable); end
        @(negedge CLOCK_50);
        checks++; if (write_enable !== 1'b1) begin errors++; $display("[TB] FAIL fp_we1: got %0h expected 1", write_enable); end
        checks++; if (WA !== 3'd2) begin errors++; $display("[TB] FAIL fp_wa_first: got %0h expected 2", WA); end
        checks++; if (WD !== 32'h22) begin errors++; $display("[TB] FAIL fp_wd_first: got %0h expected 22", WD); end
        checks++; if (conflict_cnt !== 16'd1) begin errors++; $display("[TB] FAIL fp_cnt: got %0h expected 1", conflict_cnt); end
        @(negedge CLOCK_50);
        checks++; if (write_enable !== 1'b1) begin errors++; $display("[TB] FAIL fp_we2: got %0h expected 1", write_enable); end
        checks++; if (WA !== 3'd1) begin errors++; $display("[TB] FAIL fp_wa_second: got %0h expected 1", WA); end
        checks++; if (WD !== 32'h11) begin errors++; $display("[TB] FAIL fp_wd_second: got %0h expected 11", WD); end
        checks++; if (conflict_cnt !== 16'd1) begin errors++; $display("[TB] FAIL fp_cnt_hold: got %0h expected 1", conflict_cnt); end
        @(negedge CLOCK_50);
        checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL fp_idle_we: got %0h expected 0", write_enable); end
        exp_cnt = 16'd1;
    endtask
`endif

    task automatic test_single_write;
        a_bus.valid = 1'b1; a_bus.addr = 3'd3; a_bus.data = 32'h0000_1234;
        rsv_valid = 1'b1; rsv_addr = 3'd3;
        @(negedge CLOCK_50);
        a_bus.valid = 1'b0; rsv_valid = 1'b0;
        checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL sw_we0: got %0h expected 0", write_enable); end
        checks++; if (busy !== 8'h08) begin errors++; $display("[TB] FAIL sw_busy_set: got %0h expected 08", busy); end
        @(negedge CLOCK_50);
        checks++; if (write_enable !== 1'b1) begin errors++; $display("[TB] FAIL sw_we1: got %0h expected 1", write_enable); end
        checks++; if (WA !== 3'd3) begin errors++; $display("[TB] FAIL sw_wa: got %0h expected 3", WA); end
        checks++; if (WD !== 32'h0000_1234) begin errors++; $display("[TB] FAIL sw_wd: got %0h expected 1234", WD); end
        checks++; if (busy !== 8'h08) begin errors++; $display("[TB] FAIL sw_busy_pending: got %0h expected 08", busy); end
        @(negedge CLOCK_50);
        checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL sw_we2: got %0h expected 0", write_enable); end
        checks++; if (busy !== 8'h00) begin errors++; $display("[TB] FAIL sw_busy_clr: got %0h expected 00", busy); end
        checks++; if (WA !== 3'd3) begin errors++; $display("[TB] FAIL sw_wa_hold: got %0h expected 3", WA); end
        checks++; if (WD !== 32'h0000_1234) begin errors++; $display("[TB] FAIL sw_wd_hold: got %0h expected 1234", WD); end
        checks++; if (conflict_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL sw_cnt: got %0h expected %0h", conflict_cnt, exp_cnt); end
    endtask

    task automatic test_addr_zero;
        b_bus.valid = 1'b1; b_bus.addr = 3'd0; b_bus.data = 32'hDEAD_BEEF;
        rsv_valid = 1'b1; rsv_addr = 3'd6;
        checks++; if (b_bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL z_b_ready0: got %0h expected 1", b_bus.ready); end
        @(negedge CLOCK_50);
        b_bus.valid = 1'b0; rsv_valid = 1'b0;
        checks++; if (b_bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL z_b_ready1: got %0h expected 1", b_bus.ready); end
        checks++; if (busy !== 8'h40) begin errors++; $display("[TB] FAIL z_busy1: got %0h expected 40", busy); end
        @(negedge CLOCK_50);
        checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL z_we: got %0h expected 0", write_enable); end
        checks++; if (busy !== 8'h40) begin errors++; $display("[TB] FAIL z_busy2: got %0h expected 40", busy); end
        @(negedge CLOCK_50);
        checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL z_we_after: got %0h expected 0", write_enable); end
    endtask

    task automatic test_rsv_commit_same;
        a_bus.valid = 1'b1; a_bus.addr = 3'd5; a_bus.data = 32'h0000_0055;
        rsv_valid = 1'b1; rsv_addr = 3'd5;
        @(negedge CLOCK_50);
        a_bus.valid = 1'b0; rsv_valid = 1'b0;
        checks++; if (busy !== 8'h60) begin errors++; $display("[TB] FAIL rc_busy_set: got %0h expected 60", busy); end
        @(negedge CLOCK_50);
        checks++; if (write_enable !== 1'b1) begin errors++; $display("[TB] FAIL rc_we: got %0h expected 1", write_enable); end
        checks++; if (WA !== 3'd5) begin errors++; $display("[TB] FAIL rc_wa: got %0h expected 5", WA); end
        rsv_valid = 1'b1; rsv_addr = 3'd5;
        @(negedge CLOCK_50);
        rsv_valid = 1'b0;
        checks++; if (busy !== 8'h60) begin errors++; $display("[TB] FAIL rc_busy_collide: got %0h expected 60", busy); end
        checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL rc_we_idle: got %0h expected 0", write_enable); end
        @(negedge CLOCK_50);
        checks++; if (busy !== 8'h60) begin errors++; $display("[TB] FAIL rc_busy_hold: got %0h expected 60", busy); end
    endtask

    task automatic test_reset_midflight;
        a_bus.valid = 1'b1; a_bus.addr = 3'd4; a_bus.data = 32'h0000_0044;
        b_bus.valid = 1'b1; b_bus.addr = 3'd7; b_bus.data = 32'h0000_0077;
        @(negedge CLOCK_50);
        a_bus.valid = 1'b0; b_bus.valid = 1'b0;
        @(negedge CLOCK_50);
        checks++; if (write_enable !== 1'b1) begin errors++; $display("[TB] FAIL rm_we_pre: got %0h expected 1", write_enable); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL rm_we: got %0h expected 0", write_enable); end
        checks++; if (WA !== 3'd0) begin errors++; $display("[TB] FAIL rm_wa: got %0h expected 0", WA); end
        checks++; if (WD !== 32'd0) begin errors++; $display("[TB] FAIL rm_wd: got %0h expected 0", WD); end
        checks++; if (busy !== 8'h00) begin errors++; $display("[TB] FAIL rm_busy: got %0h expected 0", busy); end
        checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rm_cnt: got %0h expected 0", conflict_cnt); end
        checks++; if (a_bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL rm_a_ready: got %0h expected 0", a_bus.ready); end
        checks++; if (b_bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL rm_b_ready: got %0h expected 0", b_bus.ready); end
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(negedge CLOCK_50);
        checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL rm_we_rel: got %0h expected 0", write_enable); end
        checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rm_cnt_rel: got %0h expected 0", conflict_cnt); end
        checks++; if (a_bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_a_ready_rel: got %0h expected 1", a_bus.ready); end
        checks++; if (b_bus.ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_b_ready_rel: got %0h expected 1", b_bus.ready); end
        @(negedge CLOCK_50);
        checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL rm_we_rel2: got %0h expected 0", write_enable); end
        checks++; if (WA !== 3'd0) begin errors++; $display("[TB] FAIL rm_wa_rel: got %0h expected 0", WA); end
        exp_cnt = 16'd0;
    endtask

    initial begin
        reset_n     = 1'b0;
        a_bus.valid = 1'b0; a_bus.addr = '0; a_bus.data = '0;
        b_bus.valid = 1'b0; b_bus.addr = '0; b_bus.data = '0;
        rsv_valid   = 1'b0; rsv_addr = '0;
        exp_cnt     = 16'd0;

        test_reset();
`ifdef WB_ROUND_ROBIN_EN
        test_round_robin();
`else
        test_fixed_priority();
`endif
        test_single_write();
        test_addr_zero();
        test_rsv_commit_same();
        test_reset_midflight();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
